// File: rtl/ice_spi_txn_seq.sv
// Transaction sequencer feeding ice_spi_masterif: TX FIFO with per-byte last tag, CS-held multi-byte transfers, idle gap.
// Optional RX capture of the master's received byte is enabled by defining ICE_SPI_SEQ_RXCAP_EN.
module ice_spi_txn_seq #(
    parameter int DEPTH     = 16,
    parameter int CS_GAP    = 4,
    parameter int UNDER_TMO = 64
) (
    input  logic                     i_spi_clk,
    input  logic                     i_spi_rst,
    input  logic                     i_wr_en,
    input  logic [7:0]               i_wr_data,
    input  logic                     i_wr_last,
    input  logic                     i_go,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_busy,
    output logic                     o_ovf,
    output logic                     o_err,
    input  logic                     i_clr,
    output logic                     o_mst_load_n,
    output logic [7:0]               o_mst_data,
    output logic                     o_mst_txen_n,
    input  logic                     i_mst_done,
`ifdef ICE_SPI_SEQ_RXCAP_EN
    output logic [7:0]               o_rx_data,
    output logic                     o_rx_vld,
`endif
    input  logic [7:0]               i_mst_rx
);

    localparam int AW   = $clog2(DEPTH);
    localparam int TMAX = (UNDER_TMO > CS_GAP) ? UNDER_TMO : CS_GAP;
    localparam int CW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_WAIT, S_GAP} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   tmr_q, tmr_d;
    logic [8:0]      mem_q [DEPTH];
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [AW:0]     cnt_q;
    logic [8:0]      head;
    logic            push, pop;
    logic            last_q, in_txn_q;
    logic [7:0]      data_q;
    logic            ovf_q, err_q, err_set;

    assign head    = mem_q[rptr_q];
    assign o_full  = (cnt_q == (AW+1)'(DEPTH));
    assign o_empty = (cnt_q == '0);
    assign o_level = cnt_q;
    assign pop     = (state_q == S_LOAD);
    // A pop in the same cycle frees a slot, so a write to a full FIFO is still accepted.
    assign push    = i_wr_en && (!o_full || pop);

    always_ff @(posedge i_spi_clk) begin
        if (push) mem_q[wptr_q] <= {i_wr_last, i_wr_data};
    end

    always_ff @(posedge i_spi_clk or negedge i_spi_rst) begin
        if (!i_spi_rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        err_set = 1'b0;
        case (state_q)
            S_IDLE:  if (i_go && !o_empty) state_d = S_LOAD;
            S_LOAD:  state_d = S_SHIFT;
            S_SHIFT: begin
                if (i_mst_done) begin
                    if (last_q)        state_d = S_GAP;
                    else if (!o_empty) state_d = S_LOAD;
                    else               state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!o_empty) begin
                    state_d = S_LOAD;
                end else if (tmr_q == CW'(UNDER_TMO - 1)) begin
                    state_d = S_GAP;
                    err_set = 1'b1;
                end
            end
            S_GAP:   if (tmr_q == CW'(CS_GAP - 1)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Timer counts residency in WAIT/GAP and restarts on every state change.
        tmr_d = '0;
        if (state_d == state_q && (state_q == S_WAIT || state_q == S_GAP))
            tmr_d = tmr_q + 1'b1;
    end

    always_ff @(posedge i_spi_clk or negedge i_spi_rst) begin
        if (!i_spi_rst) begin
            state_q  <= S_IDLE;
            tmr_q    <= '0;
            last_q   <= 1'b0;
            in_txn_q <= 1'b0;
            data_q   <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            if (pop) last_q <= head[8];
            if (state_d == S_LOAD) data_q <= head[7:0];
            // Marks loads after the first byte so CS stays asserted across them.
            in_txn_q <= (state_q != S_IDLE) &&
                        (state_d == S_LOAD || state_d == S_SHIFT || state_d == S_WAIT);
            if (i_wr_en && o_full && !pop) ovf_q <= 1'b1;
            else if (i_clr)                ovf_q <= 1'b0;
            if (err_set)                   err_q <= 1'b1;
            else if (i_clr)                err_q <= 1'b0;
        end
    end

    assign o_busy       = (state_q != S_IDLE);
    assign o_ovf        = ovf_q;
    assign o_err        = err_q;
    assign o_mst_data   = data_q;
    assign o_mst_load_n = (state_q != S_LOAD);
    assign o_mst_txen_n = !((state_q == S_SHIFT) || (state_q == S_WAIT) ||
                            (state_q == S_LOAD && in_txn_q));

`ifdef ICE_SPI_SEQ_RXCAP_EN
    logic [7:0] rx_data_q;
    logic       rx_vld_q;

    always_ff @(posedge i_spi_clk or negedge i_spi_rst) begin
        if (!i_spi_rst) begin
            rx_data_q <= '0;
            rx_vld_q  <= 1'b0;
        end else begin
            rx_vld_q <= i_mst_done && (state_q == S_SHIFT);
            if (i_mst_done && state_q == S_SHIFT) rx_data_q <= i_mst_rx;
        end
    end

    assign o_rx_data = rx_data_q;
    assign o_rx_vld  = rx_vld_q;
`else
    logic unused_rx;
    assign unused_rx = ^i_mst_rx;
`endif

endmodule

// File: tb/tb_ice_spi_txn_seq.sv
// Directed bench for ice_spi_txn_seq: queue model of the FIFO checked every cycle plus hand-timed sequencing checks.
module tb_ice_spi_txn_seq;
    localparam int DEPTH = 16;

    logic       clk, rst;
    logic       wr_en, wr_last, go, clr, man_done, auto_done, mst_done;
    logic [7:0] wr_data, mst_rx;
    logic       full, empty, busy, ovf, err, load_n, txen_n;
    logic [4:0] level;
    logic [7:0] mst_data;
`ifdef ICE_SPI_SEQ_RXCAP_EN
    logic [7:0] rx_data;
    logic       rx_vld;
`endif

    int checks = 0;
    int errors = 0;
    logic       auto_en, prev_load;
    logic [7:0] mq[$];
    logic       m_ovf;

    assign mst_done = man_done | auto_done;

    ice_spi_txn_seq #(.DEPTH(DEPTH), .CS_GAP(4), .UNDER_TMO(64)) dut (
        .i_spi_clk(clk), .i_spi_rst(rst), .i_wr_en(wr_en), .i_wr_data(wr_data),
        .i_wr_last(wr_last), .i_go(go), .o_full(full), .o_empty(empty), .o_level(level),
        .o_busy(busy), .o_ovf(ovf), .o_err(err), .i_clr(clr), .o_mst_load_n(load_n),
        .o_mst_data(mst_data), .o_mst_txen_n(txen_n), .i_mst_done(mst_done),
`ifdef ICE_SPI_SEQ_RXCAP_EN
        .o_rx_data(rx_data), .o_rx_vld(rx_vld),
`endif
        .i_mst_rx(mst_rx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Apply inputs just after a rising edge, then return at the falling edge to observe.
    task automatic cyc(input logic we, input logic [7:0] d, input logic l,
                       input logic g, input logic dn, input logic c);
        @(posedge clk);
        #1;
        wr_en = we; wr_data = d; wr_last = l; go = g; man_done = dn; clr = c;
        @(negedge clk);
    endtask

    // Master stand-in: answers each load with a done one cycle later.
    always @(negedge clk) begin
        auto_done = auto_en && prev_load;
        prev_load = auto_en && !load_n;
    end

    // Queue model of FIFO occupancy, order and overflow, compared every cycle.
    always @(negedge clk) begin
        logic pop;
        int   sz;
        if (!rst) begin
            mq.delete();
            m_ovf = 1'b0;
        end
        chk("level", 32'(level), 32'(mq.size()));
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        chk("full",  32'(full),  32'(mq.size() == DEPTH));
        chk("ovf",   32'(ovf),   32'(m_ovf));
        if (!busy) chk("idle_outs", {30'd0, load_n, txen_n}, 32'd3);
        pop = !load_n;
        if (pop) begin
            if (mq.size() == 0) begin
                chk("load_on_empty", 32'(mq.size()), 32'd1);
            end else begin
                chk("load_data", 32'(mst_data), 32'(mq[0]));
                void'(mq.pop_front());
            end
        end
        if (rst) begin
            sz = mq.size() + (pop ? 1 : 0);
            if (wr_en && (sz < DEPTH || pop)) mq.push_back(wr_data);
            if (wr_en && sz == DEPTH && !pop) m_ovf = 1'b1;
            else if (clr)                     m_ovf = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit done_ok;
        rst = 1'b0; wr_en = 0; wr_data = 0; wr_last = 0; go = 0; clr = 0;
        man_done = 0; mst_rx = 8'h00; auto_en = 0; auto_done = 0; prev_load = 0;
        repeat (2) @(negedge clk);
        chk("rst_load_n", 32'(load_n), 32'd1);
        chk("rst_txen_n", 32'(txen_n), 32'd1);
        chk("rst_data",   32'(mst_data), 32'd0);
        chk("rst_busy",   32'(busy), 32'd0);
        chk("rst_err",    32'(err), 32'd0);
        @(posedge clk); #1 rst = 1'b1;

        // Single-byte transaction
        cyc(1, 8'hA5, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        chk("t1_idle_load_n", 32'(load_n), 32'd1);
        cyc(0, 0, 0, 1, 0, 0);
        chk("t1_load_n", 32'(load_n), 32'd0);
        chk("t1_data", 32'(mst_data), 32'hA5);
        chk("t1_load_txen", 32'(txen_n), 32'd1);
        cyc(0, 0, 0, 1, 0, 0);
        chk("t1_shift_txen", 32'(txen_n), 32'd0);
        chk("t1_shift_load_n", 32'(load_n), 32'd1);
        cyc(0, 0, 0, 0, 1, 0);
        chk("t1_shift2_txen", 32'(txen_n), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 0, 0);
            chk("t1_gap_txen", 32'(txen_n), 32'd1);
            chk("t1_gap_busy", 32'(busy), 32'd1);
        end
        cyc(0, 0, 0, 0, 0, 0);
        chk("t1_back_idle", 32'(busy), 32'd0);

        // Three-byte transaction, CS held throughout
        cyc(1, 8'h01, 0, 0, 0, 0);
        cyc(1, 8'h02, 0, 0, 0, 0);
        cyc(1, 8'h03, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        chk("t2_level", 32'(level), 32'd3);
        for (int i = 0; i < 9; i++) begin
            cyc(0, 0, 0, i == 0, (i == 2 || i == 5 || i == 8), 0);
            chk("t2_load_n", 32'(load_n), 32'((i % 3) != 0));
            chk("t2_txen_n", 32'(txen_n), 32'(i == 0));
            if (i % 3 == 0) chk("t2_data", 32'(mst_data), 32'(i / 3 + 1));
        end
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 0, 0);
            chk("t2_gap_txen", 32'(txen_n), 32'd1);
        end
        cyc(0, 0, 0, 0, 0, 0);
        chk("t2_idle", 32'(busy), 32'd0);

        // Underrun timeout: WAIT lasts 64 cycles, then error and GAP
        cyc(1, 8'h10, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("t4_load_data", 32'(mst_data), 32'h10);
        cyc(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 64; i++) begin
            cyc(0, 0, 0, 0, 0, 0);
            chk("t4_wait_txen", 32'(txen_n), 32'd0);
            chk("t4_wait_err", 32'(err), 32'd0);
        end
        cyc(0, 0, 0, 0, 0, 0);
        chk("t4_to_txen", 32'(txen_n), 32'd1);
        chk("t4_to_err", 32'(err), 32'd1);
        chk("t4_to_busy", 32'(busy), 32'd1);
        repeat (3) cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("t4_idle", 32'(busy), 32'd0);
        chk("t4_err_before_clr", 32'(err), 32'd1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("t4_err_clr", 32'(err), 32'd0);

        // Refill at WAIT cycle 10 rescues the transaction
        cyc(1, 8'h10, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 8'h11, 1, 0, 0, 0);
        chk("t4b_wait_txen", 32'(txen_n), 32'd0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("t4b_level", 32'(level), 32'd1);
        chk("t4b_still_wait", 32'(load_n), 32'd1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("t4b_load_n", 32'(load_n), 32'd0);
        chk("t4b_data", 32'(mst_data), 32'h11);
        chk("t4b_load_txen", 32'(txen_n), 32'd0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("t4b_gap_txen", 32'(txen_n), 32'd1);
        chk("t4b_no_err", 32'(err), 32'd0);
        repeat (3) cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("t4b_idle", 32'(busy), 32'd0);

        // Overflow: 17 writes into 16 entries, clear, then write-while-full with pop
        for (int i = 0; i < 17; i++) cyc(1, 8'(8'h20 + i), 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("t3_full", 32'(full), 32'd1);
        chk("t3_level", 32'(level), 32'd16);
        chk("t3_ovf", 32'(ovf), 32'd1);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("t3_ovf_clr", 32'(ovf), 32'd0);
        auto_en = 1;
        cyc(1, 8'h40, 1, 1, 0, 0);
        cyc(1, 8'h41, 1, 1, 0, 0);
        chk("t3_drop_ovf", 32'(ovf), 32'd1);
        cyc(0, 0, 0, 1, 0, 0);
        chk("t3_popfull_level", 32'(level), 32'd16);
        done_ok = 0;
        for (int i = 0; i < 800 && !done_ok; i++) begin
            cyc(0, 0, 0, 1, 0, 0);
            if (empty && !busy) done_ok = 1;
        end
        chk("t3_drain_done", 32'(done_ok), 32'd1);
        cyc(0, 0, 0, 0, 0, 1);
        auto_en = 0;
        cyc(0, 0, 0, 0, 0, 0);

        // Async reset mid-SHIFT
        cyc(1, 8'h51, 0, 0, 0, 0);
        cyc(1, 8'h52, 0, 0, 0, 0);
        cyc(1, 8'h53, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("t5_in_shift", 32'(txen_n), 32'd0);
        #1 rst = 1'b0;
        #1;
        chk("t5_load_n", 32'(load_n), 32'd1);
        chk("t5_txen_n", 32'(txen_n), 32'd1);
        chk("t5_empty", 32'(empty), 32'd1);
        chk("t5_data", 32'(mst_data), 32'd0);
        @(posedge clk); @(posedge clk); #1 rst = 1'b1;
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("t5_post_idle", 32'(busy), 32'd0);

`ifdef ICE_SPI_SEQ_RXCAP_EN
        // RX capture one cycle after done
        cyc(1, 8'h77, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        mst_rx = 8'h3C;
        cyc(0, 0, 0, 0, 1, 0);
        chk("t6_pre_vld", 32'(rx_vld), 32'd0);
        cyc(0, 0, 0, 0, 0, 0);
        mst_rx = 8'h00;
        chk("t6_vld", 32'(rx_vld), 32'd1);
        chk("t6_data", 32'(rx_data), 32'h3C);
        cyc(0, 0, 0, 0, 0, 0);
        chk("t6_vld_pulse", 32'(rx_vld), 32'd0);
        chk("t6_data_hold", 32'(rx_data), 32'h3C);
        repeat (5) cyc(0, 0, 0, 0, 0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
